// File: rtl/biu_arbiter.sv
// Round-robin arbiter sharing one BIU between instruction fetch (F) and execution unit (E).
// One transfer at a time; a watchdog ends any WAIT that sees no ready_biu within TIMEOUT cycles.
module biu_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int TMR_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_fetch,
    input  logic [1:0] sel_fetch,
    input  logic [1:0] op_sel_fetch,
    input  logic       req_eu,
    input  logic [1:0] sel_eu_req,
    input  logic [1:0] op_sel_eu,
    input  logic       ready_biu,
    output logic       cs_biu,
    output logic [1:0] sel_biu,
    output logic [1:0] op_sel_biu,
    output logic       gnt_fetch,
    output logic       gnt_eu,
    output logic       done_fetch,
    output logic       done_eu,
    output logic       err,
    output logic       busy
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_DONE} state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state_q;
    logic             owner_q;       // 1 = E owns the current transfer
    logic             last_owner_q;  // 1 = E was served last
    logic [TMR_W-1:0] timer_q;
    logic             cs_q, gnt_f_q, gnt_e_q, done_f_q, done_e_q, err_q, busy_q;
    logic [1:0]       sel_q, op_q;
    logic             pick_e_d;

    // On a tie the requester that was not served last wins.
    assign pick_e_d = req_eu && !(req_fetch && last_owner_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            timer_q      <= '0;
            cs_q         <= 1'b0;
            gnt_f_q      <= 1'b0;
            gnt_e_q      <= 1'b0;
            done_f_q     <= 1'b0;
            done_e_q     <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            sel_q        <= 2'b00;
            op_q         <= 2'b00;
        end else begin
            done_f_q <= 1'b0;
            done_e_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_fetch || req_eu) begin
                        owner_q <= pick_e_d;
                        sel_q   <= pick_e_d ? sel_eu_req : sel_fetch;
                        op_q    <= pick_e_d ? op_sel_eu  : op_sel_fetch;
                        cs_q    <= 1'b1;
                        gnt_f_q <= !pick_e_d;
                        gnt_e_q <= pick_e_d;
                        busy_q  <= 1'b1;
                        timer_q <= '0;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // ready_biu wins over an expiring watchdog on the same edge.
                    if (ready_biu || (timer_q == TMR_LAST)) begin
                        cs_q     <= 1'b0;
                        gnt_f_q  <= 1'b0;
                        gnt_e_q  <= 1'b0;
                        done_f_q <= !owner_q;
                        done_e_q <= owner_q;
                        err_q    <= !ready_biu;
                        state_q  <= S_DONE;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_DONE: begin
                    last_owner_q <= owner_q;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cs_biu     = cs_q;
    assign sel_biu    = sel_q;
    assign op_sel_biu = op_q;
    assign gnt_fetch  = gnt_f_q;
    assign gnt_eu     = gnt_e_q;
    assign done_fetch = done_f_q;
    assign done_eu    = done_e_q;
    assign err        = err_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_biu_arbiter.sv
// Bench for biu_arbiter: transaction-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_biu_arbiter;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0, rst = 1'b1;
    logic       req_fetch = 1'b0, req_eu = 1'b0, ready_biu = 1'b0;
    logic [1:0] sel_fetch = 2'b00, op_sel_fetch = 2'b00, sel_eu_req = 2'b00, op_sel_eu = 2'b00;
    logic       cs_biu, gnt_fetch, gnt_eu, done_fetch, done_eu, err, busy;
    logic [1:0] sel_biu, op_sel_biu;

    int checks = 0, errors = 0, cyc = 0;
    bit chk_en = 1'b1;

    biu_arbiter #(.TIMEOUT(TIMEOUT), .TMR_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_fetch(req_fetch), .sel_fetch(sel_fetch), .op_sel_fetch(op_sel_fetch),
        .req_eu(req_eu), .sel_eu_req(sel_eu_req), .op_sel_eu(op_sel_eu),
        .ready_biu(ready_biu),
        .cs_biu(cs_biu), .sel_biu(sel_biu), .op_sel_biu(op_sel_biu),
        .gnt_fetch(gnt_fetch), .gnt_eu(gnt_eu),
        .done_fetch(done_fetch), .done_eu(done_eu), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: a transfer is "active" from grant to done; m_cyc is its position
    // (0 = grant cycle, n = n-th wait cycle); m_done marks the done cycle.
    bit       m_act, m_done, m_to, m_own_e, m_last_e;
    int       m_cyc;
    bit [1:0] m_sel, m_op;

    function automatic bit want_e(bit rf, bit re, bit last_e);
        return re && !(rf && last_e);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_act <= 0; m_done <= 0; m_to <= 0; m_own_e <= 0; m_last_e <= 0;
            m_cyc <= 0; m_sel <= 0; m_op <= 0;
        end else if (!m_act) begin
            if (req_fetch || req_eu) begin
                m_own_e <= want_e(req_fetch, req_eu, m_last_e);
                m_sel   <= want_e(req_fetch, req_eu, m_last_e) ? sel_eu_req : sel_fetch;
                m_op    <= want_e(req_fetch, req_eu, m_last_e) ? op_sel_eu  : op_sel_fetch;
                m_act <= 1; m_cyc <= 0; m_done <= 0;
            end
        end else if (m_done) begin
            m_act <= 0; m_done <= 0; m_last_e <= m_own_e;
        end else if (m_cyc == 0) begin
            m_cyc <= 1;
        end else if (ready_biu) begin
            m_done <= 1; m_to <= 0;
        end else if (m_cyc == TIMEOUT) begin
            m_done <= 1; m_to <= 1;
        end else begin
            m_cyc <= m_cyc + 1;
        end
    end

    logic gnt_log[$];
    logic pf = 1'b0, pe = 1'b0;

    always @(negedge clk) begin : cmp
        logic [10:0] a, x;
        logic        c;
        if (chk_en) begin
            c = m_act && !m_done;
            a = {cs_biu, sel_biu, op_sel_biu, gnt_fetch, gnt_eu, done_fetch, done_eu, err, busy};
            x = {c, m_sel, m_op, c && !m_own_e, c && m_own_e, m_done && !m_own_e,
                 m_done && m_own_e, m_done && m_to, m_act};
            checks++;
            if (a !== x) begin
                errors++;
                $display("FAIL outputs cyc %0d: got %b expected %b", cyc, a, x);
            end
        end
        if (gnt_fetch && !pf) gnt_log.push_back(1'b0);
        if (gnt_eu && !pe)    gnt_log.push_back(1'b1);
        pf = gnt_fetch;
        pe = gnt_eu;
    end

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (done_fetch) req_fetch = 1'b0;
        if (done_eu)    req_eu    = 1'b0;
    endtask

    task automatic wait_gnt(input bit e);
        int n = 0;
        while (((e ? gnt_eu : gnt_fetch) == 1'b0) && n < 50) begin
            tick();
            n++;
        end
        chk("wait_gnt", int'(e ? gnt_eu : gnt_fetch), 1);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        repeat (2) tick();
        chk("reset_busy", busy, 0);
        chk("reset_cs", cs_biu, 0);
        chk("reset_selop", {sel_biu, op_sel_biu}, 0);
        gnt_log.delete();

        // Simultaneous requests from reset: E first, then strict alternation.
        rst = 1'b0; ready_biu = 1'b1;
        req_fetch = 1'b1; req_eu = 1'b1;
        sel_fetch = 2'd1; op_sel_fetch = 2'd2; sel_eu_req = 2'd3; op_sel_eu = 2'd1;
        tick();
        chk("tie_first_E", gnt_eu, 1);
        chk("tie_selop", {sel_biu, op_sel_biu}, 4'b1101);
        repeat (16) begin
            tick();
            req_fetch = 1'b1; req_eu = 1'b1;
        end
        req_fetch = 1'b0; req_eu = 1'b0;
        repeat (6) tick();
        chk("tie_count", int'(gnt_log.size() >= 4), 1);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            chk("tie_order", gnt_log[i], (i % 2 == 0) ? 1 : 0);

        // Latched sel/op_sel survive requester input changes.
        ready_biu = 1'b0; req_fetch = 1'b1; sel_fetch = 2'b10; op_sel_fetch = 2'b01;
        wait_gnt(1'b0);
        repeat (2) tick();
        sel_fetch = 2'b00; op_sel_fetch = 2'b00;
        repeat (3) tick();
        chk("hold_wait", {sel_biu, op_sel_biu}, 4'b1001);
        ready_biu = 1'b1;
        tick();
        chk("hold_done_sel", {sel_biu, op_sel_biu}, 4'b1001);
        chk("hold_done_f", done_fetch, 1);
        ready_biu = 1'b0;
        tick();

        // Watchdog: 1 grant + 16 wait cycles, then done with err; pending F served next.
        req_eu = 1'b1;
        wait_gnt(1'b1);
        cnt = 0;
        while (gnt_eu && cnt < 40) begin
            cnt++;
            tick();
            if (cnt == 3) req_fetch = 1'b1;
        end
        chk("to_gnt_cycles", cnt, 17);
        chk("to_done_eu", done_eu, 1);
        chk("to_err", err, 1);
        tick(); tick();
        chk("to_then_F", gnt_fetch, 1);
        ready_biu = 1'b1;
        repeat (4) tick();

        // ready_biu on the same edge the watchdog expires: clean completion.
        ready_biu = 1'b0; req_eu = 1'b1;
        wait_gnt(1'b1);
        repeat (16) tick();
        chk("edge_still_wait", gnt_eu, 1);
        ready_biu = 1'b1;
        tick();
        chk("edge_done", done_eu, 1);
        chk("edge_err", err, 0);
        ready_biu = 1'b0;
        tick();

        // Reset during WAIT of an F transfer.
        req_fetch = 1'b1;
        wait_gnt(1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_outputs", {cs_biu, sel_biu, op_sel_biu, gnt_fetch, gnt_eu, done_fetch, done_eu, err, busy}, 0);
        rst = 1'b0; req_eu = 1'b1;
        tick();
        chk("rst_then_E", gnt_eu, 1);
        ready_biu = 1'b1;
        repeat (10) tick();

        // Randomized traffic with occasional resets and watchdog-heavy stretch.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!req_fetch && $urandom_range(3) == 0) req_fetch = 1'b1;
            else if (gnt_fetch && $urandom_range(30) == 0) req_fetch = 1'b0;
            if (!req_eu && $urandom_range(3) == 0) req_eu = 1'b1;
            else if (gnt_eu && $urandom_range(30) == 0) req_eu = 1'b0;
            sel_fetch = 2'($urandom); op_sel_fetch = 2'($urandom);
            sel_eu_req = 2'($urandom); op_sel_eu = 2'($urandom);
            ready_biu = (i < 1500) ? ($urandom_range(1) == 1) : ($urandom_range(24) == 0);
            rst = ($urandom_range(250) == 0);
        end
        rst = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
